// File: rtl/uart_tx_module.sv
// 8N1 UART transmitter, LSB first, CLK_DIV clocks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between D7 and the stop bit.
module uart_tx_module #(
    parameter logic [15:0] CLK_DIV = 16'd5120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbg_state
);

    // Handshake: a request is taken on any clock edge where the FSM is IDLE and
    // tx_start=1 (busy=0 is the "ready" indication); tx_data is captured on that
    // same edge. While busy=1 tx_start is ignored and nothing is queued.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    localparam logic [15:0] CNT_LAST = CLK_DIV - 16'd1;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [7:0]  data_q, data_nxt;
    logic        tx_nxt, busy_nxt, done_nxt;
    logic        bit_end;

    assign bit_end   = (cnt == CNT_LAST);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 16'd0;
            idx    <= 3'd0;
            data_q <= 8'd0;
            tx     <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            data_q <= data_nxt;
            tx     <= tx_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

    // tx is registered, so each branch loads the level of the bit that starts
    // on the edge it describes.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_end ? 16'd0 : cnt + 16'd1;
        idx_nxt   = idx;
        data_nxt  = data_q;
        tx_nxt    = tx;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt  = 16'd0;
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                if (tx_start) begin
                    data_nxt  = tx_data;
                    busy_nxt  = 1'b1;
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    idx_nxt   = 3'd0;
                    tx_nxt    = data_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
                        tx_nxt    = ^data_q;
`else
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        idx_nxt = idx + 3'd1;
                        tx_nxt  = data_q[idx + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    tx_nxt    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule
